// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store alignment unit: RV32 funct3 codes,
// access-size decode and the split-access state encoding.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // IDLE handles aligned accesses and the first half of a split;
    // SECOND issues the word that follows a boundary-crossing access.
    typedef enum logic {
        IDLE   = 1'b0,
        SECOND = 1'b1
    } state_t;

    // size is the access width in bytes (1, 2 or 4).
    typedef struct packed {
        logic [2:0] size;
        logic       is_signed;
        logic       legal;
    } size_info_t;

    // Unsigned byte/half codes exist only for loads; a store using them is illegal.
    function automatic size_info_t decode_size(input logic [2:0] funct3,
                                               input logic       is_store);
        size_info_t info;
        info = '{size: 3'd4, is_signed: 1'b0, legal: 1'b0};
        case (funct3)
            F3_B:    info = '{size: 3'd1, is_signed: 1'b1, legal: 1'b1};
            F3_H:    info = '{size: 3'd2, is_signed: 1'b1, legal: 1'b1};
            F3_W:    info = '{size: 3'd4, is_signed: 1'b0, legal: 1'b1};
            F3_BU:   info = '{size: 3'd1, is_signed: 1'b0, legal: !is_store};
            F3_HU:   info = '{size: 3'd2, is_signed: 1'b0, legal: !is_store};
            default: info = '{size: 3'd4, is_signed: 1'b0, legal: 1'b0};
        endcase
        return info;
    endfunction

endpackage

// File: rtl/lsu_lane_fmt.sv
// Byte-lane formatting for the alignment unit. Stores: 64-bit lane-shifted
// data vector and 8-bit byte mask spanning two words. Loads: extract from a
// two-word window, truncate to the access size and sign/zero-extend.
module lsu_lane_fmt
    import lsu_pkg::*;
(
    input  logic [31:0] wdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  size,
    input  logic        is_signed,
    input  logic [31:0] lo_word,
    input  logic [31:0] hi_word,
    output logic [63:0] st_vec,
    output logic [7:0]  st_mask,
    output logic [31:0] ld_data
);

    logic [7:0]  base_mask;
    logic [63:0] ld_window;

    // Store side: shift data and mask up to the byte offset within the word pair.
    always_comb begin
        case (size)
            3'd1:    base_mask = 8'h01;
            3'd2:    base_mask = 8'h03;
            default: base_mask = 8'h0F;
        endcase
        st_vec  = {32'h0, wdata} << {offset, 3'b000};
        st_mask = base_mask << offset;
    end

    // Load side: right-justify the addressed bytes, then truncate and extend.
    always_comb begin
        ld_window = {hi_word, lo_word} >> {offset, 3'b000};
        case (size)
            3'd1:    ld_data = {{24{is_signed & ld_window[7]}},  ld_window[7:0]};
            3'd2:    ld_data = {{16{is_signed & ld_window[15]}}, ld_window[15:0]};
            default: ld_data = ld_window[31:0];
        endcase
    end

endmodule

// File: rtl/lsu_align.sv
// Load/store alignment unit between the CPU datapath and a word-organised RAM.
// Aligned accesses complete combinationally; word-crossing accesses take two
// RAM cycles with a one-cycle CPU stall, or are flagged when not allowed.
module lsu_align
    import lsu_pkg::*;
#(
    parameter bit ALLOW_MISALIGNED = 1'b1,
    parameter int CNT_WIDTH        = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    input  logic                 req_we,
    input  logic [2:0]           req_funct3,
    input  logic [31:0]          req_addr,
    input  logic [31:0]          req_wdata,
    output logic                 stall,
    output logic                 resp_valid,
    output logic [31:0]          resp_rdata,
    output logic                 err,
    output logic [CNT_WIDTH-1:0] split_count,
    output logic [31:0]          mem_addr,
    output logic [31:0]          mem_wdata,
    output logic [3:0]           mem_wenable,
    input  logic [31:0]          mem_rdata
);

    state_t      state;
    state_t      next_state;
    logic [31:0] saved_lo;
    logic        capture_lo;
    logic        count_en;

    size_info_t  info;
    logic        crossing;
    logic [31:0] word_addr;
    logic [31:0] lo_word;
    logic [31:0] hi_word;
    logic [63:0] st_vec;
    logic [7:0]  st_mask;

    assign info      = decode_size(req_funct3, req_we);
    assign crossing  = ({1'b0, req_addr[1:0]} + info.size) > 3'd4;
    assign word_addr = {req_addr[31:2], 2'b00};

    lsu_lane_fmt u_lane_fmt (
        .wdata     (req_wdata),
        .offset    (req_addr[1:0]),
        .size      (info.size),
        .is_signed (info.is_signed),
        .lo_word   (lo_word),
        .hi_word   (hi_word),
        .st_vec    (st_vec),
        .st_mask   (st_mask),
        .ld_data   (resp_rdata)
    );

    // Access sequencing: pick the RAM word, lanes and handshake for this cycle.
    always_comb begin
        // NOTE: every output gets a default before any branch so no path leaves
        // a signal unassigned, which would otherwise infer a latch.
        next_state  = state;
        mem_addr    = word_addr;
        mem_wdata   = 32'h0;
        mem_wenable = 4'b0000;
        stall       = 1'b0;
        resp_valid  = 1'b0;
        err         = 1'b0;
        capture_lo  = 1'b0;
        count_en    = 1'b0;
        lo_word     = mem_rdata;
        hi_word     = 32'h0;

        if (rst_n) begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        if (!info.legal || (crossing && !ALLOW_MISALIGNED)) begin
                            err = 1'b1;
                        end else begin
                            if (req_we) begin
                                mem_wenable = st_mask[3:0];
                                mem_wdata   = st_vec[31:0];
                            end
                            if (crossing) begin
                                // First word of a split: hold the CPU, keep the low word.
                                capture_lo = !req_we;
                                stall      = 1'b1;
                                next_state = SECOND;
                            end else begin
                                resp_valid = !req_we;
                            end
                        end
                    end
                end
                SECOND: begin
                    mem_addr   = word_addr + 32'd4;
                    lo_word    = saved_lo;
                    hi_word    = mem_rdata;
                    next_state = IDLE;
                    // Dropping req_valid here abandons the split with no second access.
                    if (req_valid) begin
                        if (req_we) begin
                            mem_wenable = st_mask[7:4];
                            mem_wdata   = st_vec[63:32];
                        end else begin
                            resp_valid = 1'b1;
                        end
                        count_en = 1'b1;
                    end
                end
                default: next_state = IDLE;
            endcase
        end
    end

    // State, low-word capture and split counter.
    always_ff @(posedge clk) begin
        // NOTE: registered state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (!rst_n) begin
            state       <= IDLE;
            saved_lo    <= 32'h0;
            split_count <= '0;
        end else begin
            state <= next_state;
            if (capture_lo) begin
                saved_lo <= mem_rdata;
            end
            if (count_en) begin
                split_count <= split_count + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_lsu_align.sv
// Directed bench for lsu_align: a behavioural word RAM, a byte-wise reference
// memory for expected load data, and a scoreboard queue of expected responses.
module tb_lsu_align;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        stall, resp_valid, err;
    logic [31:0] resp_rdata;
    logic [31:0] split_count;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wenable;

    // Second instance with misaligned accesses disallowed.
    logic        n_req_valid, n_req_we;
    logic [2:0]  n_req_funct3;
    logic [31:0] n_req_addr, n_req_wdata;
    logic        n_stall, n_resp_valid, n_err;
    logic [31:0] n_resp_rdata, n_split_count, n_mem_addr, n_mem_wdata;
    logic [3:0]  n_mem_wenable;
    logic [31:0] n_mem_rdata;
    assign n_mem_rdata = 32'hA5A5_5A5A;

    logic [31:0] ram     [256];
    logic [31:0] ref_mem [256];
    logic        tb_we;
    logic [7:0]  tb_idx;
    logic [31:0] tb_data;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_splits = 32'd0;

    logic [2:0]  sweep_f3   [8] = '{F3_B, F3_BU, F3_H, F3_HU, F3_W, F3_W, F3_H, F3_HU};
    logic [31:0] sweep_addr [8] = '{32'h101, 32'h107, 32'h102, 32'h106,
                                    32'h104, 32'h101, 32'h107, 32'h101};

    always #5 clk = ~clk;

    lsu_align #(.ALLOW_MISALIGNED(1'b1), .CNT_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_we(req_we), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .stall(stall), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .err(err), .split_count(split_count),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wenable(mem_wenable),
        .mem_rdata(mem_rdata)
    );

    lsu_align #(.ALLOW_MISALIGNED(1'b0), .CNT_WIDTH(32)) dut_strict (
        .clk(clk), .rst_n(rst_n),
        .req_valid(n_req_valid), .req_we(n_req_we), .req_funct3(n_req_funct3),
        .req_addr(n_req_addr), .req_wdata(n_req_wdata),
        .stall(n_stall), .resp_valid(n_resp_valid), .resp_rdata(n_resp_rdata),
        .err(n_err), .split_count(n_split_count),
        .mem_addr(n_mem_addr), .mem_wdata(n_mem_wdata), .mem_wenable(n_mem_wenable),
        .mem_rdata(n_mem_rdata)
    );

    // Word RAM: combinational read, byte-lane write on the rising edge.
    assign mem_rdata = ram[mem_addr[9:2]];
    always @(posedge clk) begin
        if (tb_we) begin
            ram[tb_idx] <= tb_data;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (mem_wenable[i]) ram[mem_addr[9:2]][8*i +: 8] <= mem_wdata[8*i +: 8];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic we, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd);
        req_valid  = v;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
    endtask

    task automatic n_drive(input logic v, input logic we, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd);
        n_req_valid  = v;
        n_req_we     = we;
        n_req_funct3 = f3;
        n_req_addr   = a;
        n_req_wdata  = wd;
    endtask

    task automatic poke(input logic [7:0] idx, input logic [31:0] data);
        tb_we        = 1'b1;
        tb_idx       = idx;
        tb_data      = data;
        ref_mem[idx] = data;
        tick();
        tb_we = 1'b0;
    endtask

    function automatic int size_of(input logic [2:0] f3);
        return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic [7:0] ref_byte(input logic [31:0] a);
        return ref_mem[a[9:2]][{a[1:0], 3'b000} +: 8];
    endfunction

    // Byte-by-byte little-endian load from the reference memory.
    function automatic logic [31:0] model_load(input logic [31:0] a, input logic [2:0] f3);
        int          n = size_of(f3);
        logic [31:0] r = 32'h0;
        for (int k = 0; k < n; k++) r[8*k +: 8] = ref_byte(a + 32'(k));
        if (!f3[2] && n < 4 && r[8*n-1]) begin
            for (int j = 8*n; j < 32; j++) r[j] = 1'b1;
        end
        return r;
    endfunction

    task automatic model_store(input logic [31:0] a, input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] b;
        for (int k = 0; k < size_of(f3); k++) begin
            b = a + 32'(k);
            ref_mem[b[9:2]][{b[1:0], 3'b000} +: 8] = wd[8*k +: 8];
        end
    endtask

    // Sample at the falling edge: a response must be present and match the queue head.
    task automatic sb_sample(input string tag);
        check({tag, "_valid"}, 32'(resp_valid), 32'd1);
        if (resp_valid && exp_q.size() > 0) check(tag, resp_rdata, exp_q.pop_front());
    endtask

    // Issue a load, wait a bounded number of cycles for its response and
    // check data, latency (1 aligned, 2 split) and the split counter.
    task automatic load_op(input string tag, input logic [2:0] f3, input logic [31:0] a);
        int lat;
        int cyc;
        bit got;
        lat = ((int'(a[1:0]) + size_of(f3)) > 4) ? 2 : 1;
        if (lat == 2) exp_splits++;
        exp_q.push_back(model_load(a, f3));
        drive(1'b1, 1'b0, f3, a, 32'h0);
        got = 1'b0;
        cyc = 0;
        while (!got && cyc < 4) begin
            @(negedge clk);
            cyc++;
            if (resp_valid) begin
                got = 1'b1;
                check(tag, resp_rdata, exp_q.pop_front());
            end
            tick();
        end
        drive(1'b0, 1'b0, F3_W, 32'h0, 32'h0);
        if (!got) void'(exp_q.pop_front());
        check({tag, "_latency"}, 32'(cyc), 32'(lat));
        check({tag, "_splits"}, split_count, exp_splits);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        tb_we = 1'b0;
        tb_idx = 8'h0;
        tb_data = 32'h0;
        drive(1'b0, 1'b0, F3_W, 32'h0, 32'h0);
        n_drive(1'b0, 1'b0, F3_W, 32'h0, 32'h0);
        tick();

        // Reset: a crossing load and an aligned store are both ignored.
        drive(1'b1, 1'b0, F3_W, 32'h102, 32'h0);
        @(negedge clk);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_split_count", split_count, 32'd0);
        tick();
        drive(1'b1, 1'b1, F3_W, 32'h100, 32'h12345678);
        @(negedge clk);
        check("rst_wenable", 32'(mem_wenable), 32'd0);
        tick();
        drive(1'b0, 1'b0, F3_W, 32'h0, 32'h0);
        rst_n = 1'b1;

        // Aligned LW, same-cycle response.
        poke(8'd64, 32'hDEADBEEF);
        exp_q.push_back(32'hDEADBEEF);
        drive(1'b1, 1'b0, F3_W, 32'h100, 32'h0);
        @(negedge clk);
        check("lw_mem_addr", mem_addr, 32'h100);
        check("lw_stall", 32'(stall), 32'd0);
        check("lw_wenable", 32'(mem_wenable), 32'd0);
        sb_sample("lw_aligned");
        tick();
        drive(1'b0, 1'b0, F3_W, 32'h0, 32'h0);
        @(negedge clk);
        check("idle_resp_valid", 32'(resp_valid), 32'd0);
        tick();

        // Byte loads with sign/zero extension.
        poke(8'd64, 32'h0080_0000);
        load_op("lb_0x102", F3_B, 32'h102);
        load_op("lbu_0x102", F3_BU, 32'h102);

        // Aligned SH into the upper half.
        drive(1'b1, 1'b1, F3_H, 32'h102, 32'h0000BEEF);
        @(negedge clk);
        check("sh_wenable", 32'(mem_wenable), 32'hC);
        check("sh_wdata", mem_wdata, 32'hBEEF0000);
        check("sh_stall", 32'(stall), 32'd0);
        check("sh_resp_valid", 32'(resp_valid), 32'd0);
        tick();
        drive(1'b0, 1'b0, F3_W, 32'h0, 32'h0);
        model_store(32'h102, F3_H, 32'h0000BEEF);
        check("sh_ram", ram[64], 32'hBEEF0000);

        // Split LH across 0x103/0x104.
        poke(8'd64, 32'h11223344);
        poke(8'd65, 32'h55667788);
        exp_q.push_back(32'hFFFF8811);
        drive(1'b1, 1'b0, F3_H, 32'h103, 32'h0);
        @(negedge clk);
        check("lh_c1_mem_addr", mem_addr, 32'h100);
        check("lh_c1_stall", 32'(stall), 32'd1);
        check("lh_c1_resp_valid", 32'(resp_valid), 32'd0);
        tick();
        @(negedge clk);
        check("lh_c2_mem_addr", mem_addr, 32'h104);
        check("lh_c2_stall", 32'(stall), 32'd0);
        sb_sample("lh_cross");
        tick();
        drive(1'b0, 1'b0, F3_W, 32'h0, 32'h0);
        exp_splits++;
        check("lh_split_count", split_count, exp_splits);
        load_op("lhu_cross", F3_HU, 32'h103);

        // Split SW across 0x102..0x105.
        drive(1'b1, 1'b1, F3_W, 32'h102, 32'hAABBCCDD);
        @(negedge clk);
        check("sw_c1_mem_addr", mem_addr, 32'h100);
        check("sw_c1_wenable", 32'(mem_wenable), 32'hC);
        check("sw_c1_wdata", mem_wdata, 32'hCCDD0000);
        check("sw_c1_stall", 32'(stall), 32'd1);
        tick();
        @(negedge clk);
        check("sw_c2_mem_addr", mem_addr, 32'h104);
        check("sw_c2_wenable", 32'(mem_wenable), 32'h3);
        check("sw_c2_wdata", mem_wdata, 32'h0000AABB);
        check("sw_c2_stall", 32'(stall), 32'd0);
        check("sw_c2_resp_valid", 32'(resp_valid), 32'd0);
        tick();
        drive(1'b0, 1'b0, F3_W, 32'h0, 32'h0);
        exp_splits++;
        model_store(32'h102, F3_W, 32'hAABBCCDD);
        check("sw_split_count", split_count, exp_splits);
        check("sw_ram_lo", ram[64], 32'hCCDD3344);
        check("sw_ram_hi", ram[65], 32'h5566AABB);

        // Mixed-size sweep against the byte-wise reference.
        for (int i = 0; i < 8; i++) begin
            load_op($sformatf("sweep%0d", i), sweep_f3[i], sweep_addr[i]);
        end

        // Split LW at the top of the address space wraps to word 0.
        poke(8'd255, 32'h12345678);
        poke(8'd0, 32'h9ABCDEF0);
        exp_q.push_back(32'hDEF01234);
        drive(1'b1, 1'b0, F3_W, 32'hFFFFFFFE, 32'h0);
        @(negedge clk);
        check("wrap_c1_mem_addr", mem_addr, 32'hFFFFFFFC);
        check("wrap_c1_stall", 32'(stall), 32'd1);
        tick();
        @(negedge clk);
        check("wrap_c2_mem_addr", mem_addr, 32'h00000000);
        sb_sample("lw_wrap");
        tick();
        drive(1'b0, 1'b0, F3_W, 32'h0, 32'h0);
        exp_splits++;
        check("wrap_split_count", split_count, exp_splits);

        // Illegal funct3 codes.
        drive(1'b1, 1'b0, 3'b011, 32'h100, 32'h0);
        @(negedge clk);
        check("f3_011_err", 32'(err), 32'd1);
        check("f3_011_resp_valid", 32'(resp_valid), 32'd0);
        check("f3_011_stall", 32'(stall), 32'd0);
        tick();
        drive(1'b1, 1'b1, F3_BU, 32'h100, 32'h000000FF);
        @(negedge clk);
        check("sbu_err", 32'(err), 32'd1);
        check("sbu_wenable", 32'(mem_wenable), 32'd0);
        tick();
        drive(1'b1, 1'b0, 3'b110, 32'h103, 32'h0);
        @(negedge clk);
        check("f3_110_err", 32'(err), 32'd1);
        check("f3_110_stall", 32'(stall), 32'd0);
        tick();
        drive(1'b0, 1'b0, F3_W, 32'h0, 32'h0);
        @(negedge clk);
        check("idle_err", 32'(err), 32'd0);
        tick();
        load_op("after_err", F3_W, 32'h104);

        // Abort a split load in its second cycle.
        drive(1'b1, 1'b0, F3_W, 32'h105, 32'h0);
        @(negedge clk);
        check("abort_c1_stall", 32'(stall), 32'd1);
        tick();
        drive(1'b0, 1'b0, F3_W, 32'h105, 32'h0);
        @(negedge clk);
        check("abort_resp_valid", 32'(resp_valid), 32'd0);
        check("abort_wenable", 32'(mem_wenable), 32'd0);
        check("abort_stall", 32'(stall), 32'd0);
        tick();
        check("abort_split_count", split_count, exp_splits);
        load_op("after_abort", F3_W, 32'h100);

        // Reset during the second cycle of a split store.
        poke(8'd66, 32'h01020304);
        drive(1'b1, 1'b1, F3_W, 32'h106, 32'hCAFEF00D);
        @(negedge clk);
        check("rsplit_c1_wenable", 32'(mem_wenable), 32'hC);
        check("rsplit_c1_wdata", mem_wdata, 32'hF00D0000);
        tick();
        rst_n = 1'b0;
        @(negedge clk);
        check("rsplit_c2_wenable", 32'(mem_wenable), 32'd0);
        check("rsplit_c2_stall", 32'(stall), 32'd0);
        tick();
        rst_n = 1'b1;
        drive(1'b0, 1'b0, F3_W, 32'h0, 32'h0);
        exp_splits = 32'd0;
        @(negedge clk);
        check("rsplit_stall_after", 32'(stall), 32'd0);
        check("rsplit_split_count", split_count, 32'd0);
        check("rsplit_ram_first", ram[65], 32'hF00DAABB);
        check("rsplit_ram_second", ram[66], 32'h01020304);
        ref_mem[65] = 32'hF00DAABB;
        tick();

        // Misaligned accesses disallowed.
        n_drive(1'b1, 1'b0, F3_W, 32'h101, 32'h0);
        @(negedge clk);
        check("strict_lw_err", 32'(n_err), 32'd1);
        check("strict_lw_wenable", 32'(n_mem_wenable), 32'd0);
        check("strict_lw_stall", 32'(n_stall), 32'd0);
        check("strict_lw_resp_valid", 32'(n_resp_valid), 32'd0);
        tick();
        n_drive(1'b1, 1'b1, F3_W, 32'h102, 32'h11111111);
        @(negedge clk);
        check("strict_sw_err", 32'(n_err), 32'd1);
        check("strict_sw_wenable", 32'(n_mem_wenable), 32'd0);
        tick();
        n_drive(1'b1, 1'b0, F3_W, 32'h100, 32'h0);
        @(negedge clk);
        check("strict_aligned_err", 32'(n_err), 32'd0);
        check("strict_aligned_resp_valid", 32'(n_resp_valid), 32'd1);
        check("strict_aligned_rdata", n_resp_rdata, 32'hA5A55A5A);
        tick();
        n_drive(1'b0, 1'b0, F3_W, 32'h0, 32'h0);
        @(negedge clk);
        check("strict_split_count", n_split_count, 32'd0);
        check("strict_idle_stall", 32'(n_stall), 32'd0);

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lsu_align.md
Name: lsu_align

Overview:
- Load/store alignment unit between the single-cycle CPU datapath and the word-organised data RAM.
- Converts RV32 byte, half and word loads and stores into word-aligned RAM accesses with byte-lane write enables.
- Sign- or zero-extends load data.
- Splits any access that crosses a word boundary into two RAM cycles and stalls the CPU for the extra cycle.

Parameters:
- ALLOW_MISALIGNED, 1: 1 = split word-crossing accesses; 0 = flag them as errors.
- CNT_WIDTH, 32: width of the split-access performance counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- req_valid  in  1  CPU memory request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32 funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified.
- stall  out  1  CPU must hold PC and all req_* stable.
- resp_valid  out  1  load data valid on resp_rdata.
- resp_rdata  out  32  extended load result.
- err  out  1  misaligned (when disallowed) or illegal funct3.
- split_count  out  CNT_WIDTH  count of completed split accesses.
- mem_addr  out  32  word address to RAM; bits [1:0] always 00.
- mem_wdata  out  32  lane-positioned write data.
- mem_wenable  out  4  per-byte write enable.
- mem_rdata  in  32  RAM combinational read data; offset is 0, so no shift is applied by the RAM.

Behaviour:
- Reset: clk and rst_n are the only clock and reset. Reset is synchronous and active-low. While rst_n=0:
  - state = IDLE; stall, resp_valid, err and mem_wenable = 0; saved_lo = 0; split_count = 0.
- Access size: n = 1 for B/BU, 2 for H/HU, 4 for W. Offset o = req_addr[1:0].
- Crossing condition: the access crosses a word boundary iff o + n > 4.
- Lane math:
  - 64-bit store vector = {32'b0, req_wdata} << 8*o.
  - 8-bit mask = ((1<<n)-1) << o.
  - Low halves of vector and mask feed the first word; high halves feed the second word.
- IDLE, non-crossing (or req_valid=0): fully combinational, zero latency.
  - mem_addr = {req_addr[31:2], 2'b00}.
  - For a store, mem_wenable = mask[3:0].
  - For a load, resp_valid = 1 in the same cycle. resp_rdata = (mem_rdata >> 8*o), truncated to n bytes, then extended per funct3.
  - stall = 0.
- IDLE, crossing, ALLOW_MISALIGNED=1:
  - Emit the first word: store writes lanes mask[3:0]; load captures mem_rdata into saved_lo.
  - stall = 1, resp_valid = 0; next state SECOND.
- SECOND:
  - mem_addr = first word + 4, modulo 2^32, so 0xFFFFFFFC wraps to 0x00000000.
  - Store writes lanes mask[7:4] with vector[63:32].
  - Load result = ({mem_rdata, saved_lo} >> 8*o), n bytes, extended.
  - stall = 0, resp_valid = 1 for loads; split_count increments (wraps at max); next state IDLE.
- SECOND with req_valid=0 (abort): mem_wenable = 0, no response, no count, next state IDLE.
- Splits are not atomic: a reset or abort in SECOND leaves the first-word bytes written.
- Errors; all of these force mem_wenable = 0, stall = 0, resp_valid = 0, state unchanged:
  - crossing with ALLOW_MISALIGNED=0: err = 1 for that cycle;
  - funct3 011, 11x, or 1xx on a store: err = 1.
- err, resp_valid and stall are never asserted while req_valid=0 in IDLE.
- mem_wdata is don't-care when mem_wenable = 0; drive it 0.

Decomposition:
- Shared package lsu_pkg:
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU;
  - size-decode function (funct3 -> n, signed flag, legal);
  - state encoding IDLE/SECOND.
- Sub-module lsu_lane_fmt (combinational):
  - store: vector/mask generation;
  - load: 64-bit extract, truncate, extend.
- lsu_align keeps only the FSM, saved_lo, counter and muxing.

Test Plan:
- Aligned LW 0x100, RAM[0x100]=0xDEADBEEF -> same cycle resp 0xDEADBEEF, stall 0, mem_addr 0x100, wenable 0000.
- LB 0x102 with byte 0x80 -> 0xFFFFFF80. LBU -> 0x00000080. Aligned SH 0x0000BEEF to 0x102 -> wenable 1100, mem_wdata 0xBEEF0000.
- LH 0x103, RAM[0x100]=0x11223344, RAM[0x104]=0x55667788:
  - cycle 1: mem_addr 0x100, stall 1;
  - cycle 2: mem_addr 0x104, resp 0xFFFF8811, split_count 1.
  - LHU gives 0x00008811.
- SW 0xAABBCCDD to 0x102 over the same RAM:
  - cycle 1: wen 1100, wdata 0xCCDD0000;
  - cycle 2: 0x104, wen 0011, wdata 0x0000AABB;
  - RAM result: 0xCCDD3344 / 0x5566AABB.
- LW 0xFFFFFFFE -> second access at 0x00000000. rst_n=0 during SECOND of a split store -> no second write, stall 0 next cycle, split_count 0.
- ALLOW_MISALIGNED=0: LW 0x101 -> err 1, wenable 0000, stall 0. funct3=011 load -> err 1. SBU funct3 100 store -> err 1, no write.
